// File: rtl/machine_timer.sv
// machine_timer: memory-mapped mtime/mtimecmp timer with a prescaler.
// Ports: clk; rst_n (async, active-low); req_valid/req_ready/req_write/
//   req_addr/req_wdata request channel; rsp_valid/rsp_ready/rsp_rdata/
//   rsp_err response channel; timer_interrupt (registered level).
// Optional feature macro: MTIMER_PERIODIC_EN adds the PERIOD auto-reload.
module machine_timer #(
    parameter int PRESCALE_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [4:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        timer_interrupt
);

    logic acc;
    logic sel_tlo, sel_thi, sel_clo, sel_chi, sel_ctrl, sel_per;
    logic addr_ok;
    logic we_tlo, we_thi, we_clo, we_chi, we_ctrl, rd_tlo;

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] cmp_q, cmp_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic en_q, en_d;
    logic ie_q, ie_d;
    logic [31:0] shadow_q, shadow_d;

    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [31:0] rd_mux, ctrl_rd;

    logic irq_q, irq_d;
    logic tick, match, pend;

`ifdef MTIMER_PERIODIC_EN
    logic        we_per;
    logic [31:0] period_q, period_d;
    logic        pend_q, pend_d;
    logic        match_q;
    logic        rise;
`endif

    // Only one response may be outstanding.
    assign req_ready = !rsp_valid_q || rsp_ready;
    assign acc       = req_valid && req_ready;

    always_comb begin
        sel_tlo  = 1'b0;
        sel_thi  = 1'b0;
        sel_clo  = 1'b0;
        sel_chi  = 1'b0;
        sel_ctrl = 1'b0;
        sel_per  = 1'b0;
        if (req_addr[1:0] == 2'b00) begin
            case (req_addr[4:2])
                3'd0: sel_tlo  = 1'b1;
                3'd1: sel_thi  = 1'b1;
                3'd2: sel_clo  = 1'b1;
                3'd3: sel_chi  = 1'b1;
                3'd4: sel_ctrl = 1'b1;
`ifdef MTIMER_PERIODIC_EN
                3'd5: sel_per  = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign addr_ok = sel_tlo | sel_thi | sel_clo | sel_chi | sel_ctrl | sel_per;

    assign we_tlo  = acc && req_write && sel_tlo;
    assign we_thi  = acc && req_write && sel_thi;
    assign we_clo  = acc && req_write && sel_clo;
    assign we_chi  = acc && req_write && sel_chi;
    assign we_ctrl = acc && req_write && sel_ctrl;
    assign rd_tlo  = acc && !req_write && sel_tlo;

`ifdef MTIMER_PERIODIC_EN
    assign pend = pend_q;
`else
    assign pend = 1'b0;
`endif

    always_comb begin
        ctrl_rd = '0;
        ctrl_rd[0] = en_q;
        ctrl_rd[1] = ie_q;
        ctrl_rd[2] = pend;
        ctrl_rd[8 +: PRESCALE_W] = presc_q;
        rd_mux = '0;
        if (sel_tlo)       rd_mux = mtime_q[31:0];
        else if (sel_thi)  rd_mux = shadow_q;
        else if (sel_clo)  rd_mux = cmp_q[31:0];
        else if (sel_chi)  rd_mux = cmp_q[63:32];
        else if (sel_ctrl) rd_mux = ctrl_rd;
`ifdef MTIMER_PERIODIC_EN
        else if (sel_per)  rd_mux = period_q;
`endif
    end

    // mtime advances on the cycle the prescale counter equals PRESCALE.
    assign tick = en_q && (pcnt_q == presc_q);

    always_comb begin
        pcnt_d  = pcnt_q;
        mtime_d = mtime_q;
        if (en_q) begin
            pcnt_d = tick ? '0 : pcnt_q + PRESCALE_W'(1);
            if (tick) mtime_d = mtime_q + 64'd1;
        end
        // A software write to one half beats the increment; the
        // other half keeps its pre-write value.
        if (we_tlo) mtime_d = {mtime_q[63:32], req_wdata};
        if (we_thi) mtime_d = {req_wdata, mtime_q[31:0]};
        if (we_ctrl || we_tlo || we_thi) pcnt_d = '0;
    end

    always_comb begin
        en_d    = en_q;
        ie_d    = ie_q;
        presc_d = presc_q;
        if (we_ctrl) begin
            en_d    = req_wdata[0];
            ie_d    = req_wdata[1];
            presc_d = req_wdata[8 +: PRESCALE_W];
        end
        shadow_d = rd_tlo ? mtime_q[63:32] : shadow_q;
    end

    assign match = (mtime_q >= cmp_q);

`ifdef MTIMER_PERIODIC_EN
    assign we_per = acc && req_write && sel_per;
    assign rise   = match && !match_q && (period_q != '0);

    always_comb begin
        period_d = we_per ? req_wdata : period_q;
        pend_d   = pend_q;
        if (we_ctrl && req_wdata[2]) pend_d = 1'b0;
        // Set beats a same-cycle clear.
        if (rise) pend_d = 1'b1;
    end
`endif

    always_comb begin
        cmp_d = cmp_q;
        if (we_clo)      cmp_d[31:0]  = req_wdata;
        else if (we_chi) cmp_d[63:32] = req_wdata;
`ifdef MTIMER_PERIODIC_EN
        else if (rise)   cmp_d = cmp_q + {32'd0, period_q};
`endif
    end

    always_comb begin
`ifdef MTIMER_PERIODIC_EN
        irq_d = pend_q && ie_q;
`else
        irq_d = match && ie_q;
`endif
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (acc) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = !addr_ok;
            rsp_rdata_d = (!req_write && addr_ok) ? rd_mux : '0;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q     <= '0;
            cmp_q       <= '1;
            pcnt_q      <= '0;
            presc_q     <= '0;
            en_q        <= 1'b0;
            ie_q        <= 1'b0;
            shadow_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            cmp_q       <= cmp_d;
            pcnt_q      <= pcnt_d;
            presc_q     <= presc_d;
            en_q        <= en_d;
            ie_q        <= ie_d;
            shadow_q    <= shadow_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            irq_q       <= irq_d;
        end
    end

`ifdef MTIMER_PERIODIC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= '0;
            pend_q   <= 1'b0;
            match_q  <= 1'b0;
        end else begin
            period_q <= period_d;
            pend_q   <= pend_d;
            match_q  <= match;
        end
    end
`endif

    assign rsp_valid       = rsp_valid_q;
    assign rsp_rdata       = rsp_rdata_q;
    assign rsp_err         = rsp_err_q;
    assign timer_interrupt = irq_q;

endmodule
